scan_index_encoder: RTL and testbench
=====================================

Name: scan_index_encoder

Overview:
- Parametrised, handshaked successor to the 4-to-2 one-hot encoder.
- Accepts an N-bit request vector and emits the index of each set bit in priority order, one index per output handshake.
- In strict mode it emits only the highest-priority index and flags vectors that are not one-hot.
- Sits between request-collection logic and a downstream index consumer, for example a per-channel service sequencer.

Parameters:
- N, 8: request vector width; legal range N >= 2. Index width W = ceil(log2(N)), derived internally.
- MSB_FIRST, 0: 0 gives bit 0 highest priority; 1 gives bit N-1 highest priority.
- MODE, 1: 0 is strict one-hot (one beat per vector); 1 is scan (one beat per set bit).

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_vec  input  N  request vector.
- in_valid  input  1  in_vec is valid.
- in_ready  output  1  block can capture in_vec this cycle.
- out_idx  output  W  index of the current highest-priority pending bit.
- out_valid  output  1  out_idx is valid.
- out_ready  input  1  consumer accepts out_idx.
- out_last  output  1  current beat is the final beat for the captured vector.
- onehot_err  output  1  one-cycle pulse: strict mode captured a vector with more than one bit set.
- empty_pulse  output  1  one-cycle pulse: an all-zero vector was captured and dropped.

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE, pending=0, out_valid=0, out_last=0, out_idx=0, onehot_err=0, empty_pulse=0. in_ready=1 because state is IDLE.
- States: IDLE and EMIT. Held state is the N-bit pending register.
- in_ready = (state==IDLE) OR (state==EMIT AND out_last AND out_ready). This gives back-to-back vectors with no bubble.
- Capture occurs when in_valid && in_ready on a rising edge:
  - in_vec==0: pending stays 0, empty_pulse=1 next cycle, next state IDLE, no output beat.
  - MODE=1, in_vec!=0: pending=in_vec; next state EMIT.
  - MODE=0, in_vec!=0: pending = only the highest-priority set bit of in_vec; next state EMIT.
  - MODE=0, popcount(in_vec)>1: onehot_err=1 for the one cycle after capture.
- EMIT state:
  - out_valid=1.
  - out_idx = position of the highest-priority set bit of pending, per MSB_FIRST.
  - out_last = (popcount(pending)==1).
- Output hold: while out_valid && !out_ready, pending, out_idx and out_last are held stable.
- On out_valid && out_ready:
  - The emitted bit is cleared from pending.
  - If out_last is 0: stay in EMIT.
  - If out_last is 1 and a capture occurs in the same cycle: load the new vector per the capture rules. A zero vector goes to IDLE with empty_pulse.
  - If out_last is 1 and no capture occurs: go to IDLE, pending=0.
- Latency: vector captured at edge t gives its first out_valid in cycle t+1. Each further set bit costs one out handshake. k set bits need k output beats (MODE=1).
- In IDLE: out_valid=0, out_last=0, out_idx=0.
- in_vec changes while not captured are ignored. Captured data is isolated from in_vec after the capture edge.
- Reset mid-EMIT: asynchronously returns to reset values. Pending bits are discarded and no partial beat is emitted after release.
- Index arithmetic: out_idx is unsigned, 0..N-1. For non-power-of-two N, codes N..2^W-1 are never produced.

Test Plan:
- N=8, MODE=1, MSB_FIRST=0, in_vec=8'b1010_0110, out_ready=1 -> out_idx 1,2,5,7 on consecutive cycles; out_last=1 only on idx 7; in_ready=1 in the idx-7 cycle.
- Same vector with out_ready low for 3 cycles on the second beat -> out_idx=2 held stable with out_valid=1 until accepted; no beat lost or duplicated.
- MODE=0, in_vec=8'b0001_0100 -> single beat out_idx=2, out_last=1, onehot_err pulse 1 cycle. With MSB_FIRST=1 -> out_idx=4.
- in_vec=0 with in_valid=1 -> empty_pulse 1 cycle, out_valid stays 0, in_ready stays 1.
- Back-to-back: 8'h01 then 8'h80 presented continuously -> out_idx 0 then 7 in adjacent cycles, no bubble.
- rst_n low mid-scan of 8'hFF after idx 2 -> all outputs immediately at reset values; after release a new vector 8'h08 -> out_idx=3 with out_last=1.

Source files
------------

// File: rtl/scan_index_encoder.sv
// scan_index_encoder: captures a request vector and emits the index of
// each set bit in priority order, one per out handshake.
module scan_index_encoder #(
  parameter int N         = 8,
  parameter int MSB_FIRST = 0,
  parameter int MODE      = 1,
  localparam int W        = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] in_vec,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_idx,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_last,
  output logic         onehot_err,
  output logic         empty_pulse
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_EMIT = 1'b1;

  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  logic [0:0]   state_q, state_d;
  logic [N-1:0] pending_q, pending_d;
  logic         onehot_err_q, onehot_err_d;
  logic         empty_pulse_q, empty_pulse_d;

  logic         emit;
  logic         last;
  logic [W-1:0] head_idx;
  logic [N-1:0] head_bit;
  logic [W-1:0] in_idx;
  logic [N-1:0] in_bit;
  logic         in_multi;
  logic         out_fire;
  logic         capture;

  // Position of the winning set bit; zero when nothing is set.
  function automatic logic [W-1:0] prio_idx(
    input logic [N-1:0] v
  );
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) begin
      if (MSB_FIRST != 0) begin
        if (v[i]) r = W'(i);
      end else begin
        if (v[N-1-i]) r = W'(N-1-i);
      end
    end
    return r;
  endfunction

  // Head-of-pending decode and handshake qualifiers.
  always_comb begin
    emit     = (state_q == S_EMIT);
    head_idx = prio_idx(pending_q);
    head_bit = ONE << head_idx;
    last     = (pending_q != '0) &&
               ((pending_q & (pending_q - ONE)) == '0);
    in_idx   = prio_idx(in_vec);
    in_bit   = ONE << in_idx;
    in_multi = ((in_vec & (in_vec - ONE)) != '0);
    in_ready = !emit || (last && out_ready);
    out_fire = emit && out_ready;
    capture  = in_valid && in_ready;
  end

  // Retire the emitted bit, then overlay any capture this cycle.
  always_comb begin
    state_d       = state_q;
    pending_d     = pending_q;
    onehot_err_d  = 1'b0;
    empty_pulse_d = 1'b0;
    if (out_fire) begin
      pending_d = pending_q & ~head_bit;
      if (last) state_d = S_IDLE;
    end
    if (capture) begin
      if (in_vec == '0) begin
        pending_d     = '0;
        state_d       = S_IDLE;
        empty_pulse_d = 1'b1;
      end else begin
        state_d = S_EMIT;
        if (MODE == 1) begin
          pending_d = in_vec;
        end else begin
          pending_d    = in_bit;
          onehot_err_d = in_multi;
        end
      end
    end
  end

  // State and pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      pending_q     <= '0;
      onehot_err_q  <= 1'b0;
      empty_pulse_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pending_q     <= pending_d;
      onehot_err_q  <= onehot_err_d;
      empty_pulse_q <= empty_pulse_d;
    end
  end

  assign out_valid   = emit;
  assign out_idx     = emit ? head_idx : '0;
  assign out_last    = emit && last;
  assign onehot_err  = onehot_err_q;
  assign empty_pulse = empty_pulse_q;

endmodule

// File: tb/tb_scan_index_encoder.sv
// tb_scan_index_encoder: two encoder instances (scan/LSB-first and
// strict/MSB-first) checked by a queue scoreboard.
module tb_scan_index_encoder;

  typedef struct packed {
    logic [2:0] idx;
    logic       last;
  } beat_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [1:0][7:0] in_vec = '0;
  logic [1:0]      in_valid = '0;
  logic [1:0]      in_ready;
  logic [1:0][2:0] out_idx;
  logic [1:0]      out_valid;
  logic [1:0]      out_ready;
  logic [1:0]      out_last;
  logic [1:0]      onehot_err;
  logic [1:0]      empty_pulse;

  logic [1:0] auto_rdy = '0;
  logic [1:0] man_rdy = '0;
  logic [1:0] rnd_rdy = '0;

  beat_t q0[$];
  beat_t q1[$];
  bit [1:0] eerr = '0;
  bit [1:0] eemp = '0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign out_ready = (auto_rdy & rnd_rdy) | (~auto_rdy & man_rdy);

  scan_index_encoder #(.N(8), .MSB_FIRST(0), .MODE(1)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_vec(in_vec[0]), .in_valid(in_valid[0]),
    .in_ready(in_ready[0]), .out_idx(out_idx[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_last(out_last[0]), .onehot_err(onehot_err[0]),
    .empty_pulse(empty_pulse[0])
  );

  scan_index_encoder #(.N(8), .MSB_FIRST(1), .MODE(0)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_vec(in_vec[1]), .in_valid(in_valid[1]),
    .in_ready(in_ready[1]), .out_idx(out_idx[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_last(out_last[1]), .onehot_err(onehot_err[1]),
    .empty_pulse(empty_pulse[1])
  );

  function automatic int mode_of(input int d);
    return (d == 0) ? 1 : 0;
  endfunction

  function automatic int msb_of(input int d);
    return (d == 0) ? 0 : 1;
  endfunction

  function automatic int qsize(input int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  function automatic beat_t qfront(input int d);
    return (d == 0) ? q0[0] : q1[0];
  endfunction

  task automatic qpop(input int d);
    beat_t b;
    if (d == 0) b = q0.pop_front();
    else        b = q1.pop_front();
  endtask

  task automatic qpush(input int d, input beat_t b);
    if (d == 0) q0.push_back(b);
    else        q1.push_back(b);
  endtask

  task automatic qclear(input int d);
    if (d == 0) q0.delete();
    else        q1.delete();
  endtask

  task automatic chk(input string nm, input int d,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d: got %0h expected %0h",
               nm, d, act, exp);
    end
  endtask

  // Reference: walk bits in priority order and list the beats.
  task automatic model_capture(input int d, input logic [7:0] v);
    beat_t b;
    int    pop;
    int    cnt;
    int    k;
    pop = $countones(v);
    cnt = 0;
    if (v == 8'h00) begin
      eemp[d] = 1'b1;
      return;
    end
    for (int j = 0; j < 8; j++) begin
      k = (msb_of(d) == 1) ? 7 - j : j;
      if (v[k]) begin
        cnt++;
        if (mode_of(d) == 1 || cnt == 1) begin
          b.idx  = 3'(k);
          b.last = (mode_of(d) == 0) || (cnt == pop);
          qpush(d, b);
        end
      end
    end
    if (mode_of(d) == 0 && pop > 1) eerr[d] = 1'b1;
  endtask

  // Monitor: everything is stable at the falling edge.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        qclear(d);
        eerr[d] = 1'b0;
        eemp[d] = 1'b0;
        chk("rst_out_valid", d, 32'(out_valid[d]), 0);
        chk("rst_out_idx", d, 32'(out_idx[d]), 0);
        chk("rst_out_last", d, 32'(out_last[d]), 0);
        chk("rst_in_ready", d, 32'(in_ready[d]), 1);
        chk("rst_onehot_err", d, 32'(onehot_err[d]), 0);
        chk("rst_empty", d, 32'(empty_pulse[d]), 0);
      end else begin
        automatic int  sz = qsize(d);
        automatic bit  exp_ir;
        automatic beat_t b;
        exp_ir = (sz == 0) || (sz == 1 && out_ready[d]);
        chk("out_valid", d, 32'(out_valid[d]), 32'(sz != 0));
        chk("in_ready", d, 32'(in_ready[d]), 32'(exp_ir));
        chk("onehot_err", d, 32'(onehot_err[d]), 32'(eerr[d]));
        chk("empty_pulse", d, 32'(empty_pulse[d]), 32'(eemp[d]));
        if (sz != 0) begin
          b = qfront(d);
          chk("out_idx", d, 32'(out_idx[d]), 32'(b.idx));
          chk("out_last", d, 32'(out_last[d]), 32'(b.last));
          if (out_ready[d]) qpop(d);
        end else begin
          chk("idle_idx", d, 32'(out_idx[d]), 0);
          chk("idle_last", d, 32'(out_last[d]), 0);
        end
        eerr[d] = 1'b0;
        eemp[d] = 1'b0;
        if (in_valid[d] && exp_ir) model_capture(d, in_vec[d]);
      end
    end
  end

  // Random backpressure source.
  always @(posedge clk) begin
    #1;
    rnd_rdy = 2'($urandom_range(0, 3));
    rnd_rdy[0] = rnd_rdy[0] | ($urandom_range(0, 2) != 0);
    rnd_rdy[1] = rnd_rdy[1] | ($urandom_range(0, 2) != 0);
  end

  // Present a vector until accepted, then scramble in_vec.
  task automatic send(input int d, input logic [7:0] v);
    int n;
    bit ok;
    n  = 0;
    ok = 1'b0;
    in_vec[d]   = v;
    in_valid[d] = 1'b1;
    while (!ok && n < 100) begin
      @(negedge clk);
      if (in_ready[d]) ok = 1'b1;
      n++;
    end
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout dut%0d: got 0 expected 1", d);
    end
    @(posedge clk);
    #1;
    in_valid[d] = 1'b0;
    in_vec[d]   = 8'($urandom);
  endtask

  task automatic drain();
    auto_rdy = 2'b00;
    man_rdy  = 2'b11;
    repeat (12) @(posedge clk);
    #1;
  endtask

  task automatic rand_run(input int d);
    logic [7:0] v;
    for (int i = 0; i < 150; i++) begin
      v = 8'($urandom);
      if ($urandom_range(0, 7) == 0) v = 8'h00;
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      send(d, v);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    man_rdy = 2'b11;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    send(0, 8'b1010_0110);
    drain();

    send(0, 8'b1010_0110);
    @(posedge clk);
    #1;
    man_rdy[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    man_rdy[0] = 1'b1;
    drain();

    send(1, 8'b0001_0100);
    drain();
    send(1, 8'h20);
    drain();

    send(0, 8'h00);
    send(1, 8'h00);
    drain();

    send(0, 8'h01);
    send(0, 8'h80);
    drain();

    send(0, 8'hFF);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 0, 32'(out_valid[0]), 0);
    chk("async_rst_idx", 0, 32'(out_idx[0]), 0);
    chk("async_rst_last", 0, 32'(out_last[0]), 0);
    chk("async_rst_in_ready", 0, 32'(in_ready[0]), 1);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send(0, 8'h08);
    drain();

    auto_rdy = 2'b11;
    fork
      rand_run(0);
      rand_run(1);
    join
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
